sync_fifo_mem: RTL and testbench
================================

SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, data word width (32 for instruction memory, 16 for input buffer).
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 6, address width.
REQ-003 The block SHALL expose parameter DEPTH, default 64 (2^ADDR_WIDTH), number of storage words.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_cs  input  1  write chip select.
REQ-007 wr_en  input  1  write enable; write occurs only when wr_cs=1 and wr_en=1.
REQ-008 address_to_write  input  ADDR_WIDTH  write word address.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_cs  input  1  read chip select.
REQ-011 rd_en  input  1  read enable; read occurs only when rd_cs=1 and rd_en=1.
REQ-012 address_to_read  input  ADDR_WIDTH  read word address.
REQ-013 data_out  output  DATA_WIDTH  registered read data.
REQ-014 empty  output  1  occupancy count = 0.
REQ-015 full  output  1  occupancy count = DEPTH.

Function
REQ-016 Storage SHALL be DEPTH words of DATA_WIDTH bits, directly addressed (no internal read/write pointers).
REQ-017 Write accept = wr_cs & wr_en & ~full; on accept, mem[address_to_write] <= data_in at the rising edge.
REQ-018 A write request while full SHALL be dropped: memory and count unchanged.
REQ-019 Read request = rd_cs & rd_en; on request, data_out <= mem[address_to_read] at the rising edge (1-cycle latency); the read is non-destructive and occurs even when empty.
REQ-020 With no read request, data_out SHALL hold its previous value.
REQ-021 Occupancy counter width SHALL be ADDR_WIDTH+1 bits, range 0..DEPTH.
REQ-022 Count SHALL increment by 1 on an accepted write with no read decrement in the same cycle.
REQ-023 Count SHALL decrement by 1 on a read request with count>0 and no accepted write in the same cycle; a read while empty leaves count at 0 (no underflow).
REQ-024 An accepted write and a counted read in the same cycle SHALL leave count unchanged.
REQ-025 Read and write to the same address in the same cycle SHALL return the old (pre-write) word (read-before-write).
REQ-026 empty and full SHALL be registered-consistent with count: both updated in the same edge as count, never both 1.
REQ-027 Addresses SHALL be used modulo DEPTH; no out-of-range access.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force count=0, empty=1, full=0, data_out=0, and clear all memory words to 0.
REQ-029 Reset asserted mid-operation SHALL abort any in-flight access; the first rising edge after rst returns high operates normally.

Verification
REQ-030 After reset: empty=1, full=0, data_out=0; read of address 5 -> data_out=0 next cycle.
REQ-031 Write 0xA5A5_0001 at address 3, then read address 3 -> data_out=0xA5A5_0001 one cycle after the read request; empty=0 after the write.
REQ-032 64 accepted writes to addresses 0..63 -> full=1 after the 64th edge; 65th write (address 0, new data) dropped, mem[0] keeps its old value.
REQ-033 From full, simultaneous read and write request (write dropped) -> count 63, full=0; from count 10, simultaneous write and read -> count stays 10.
REQ-034 Read with rd_cs=1, rd_en=0, or wr_en=1, wr_cs=0 -> no data_out change, no memory or count change.
REQ-035 DATA_WIDTH=16 instance: write 0xBEEF at address 7, read address 7 -> data_out=0xBEEF; assert rst mid-stream -> empty=1 and data_out=0 without waiting for clk.

Source files
------------

// File: rtl/sync_fifo_mem.sv
// Directly addressed word memory with a FIFO-style occupancy counter.
// Reads are registered, non-destructive and read-before-write. Writes are dropped while full.
`timescale 1ns/1ps
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] address_to_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address_to_read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [CW-1:0]         count_reg, count_next;
    logic                  empty_reg, full_reg;
    logic                  wr_accept, rd_req, rd_count;
    logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

    // Folding keeps every access inside the array even when DEPTH < 2**ADDR_WIDTH.
    assign wr_idx = ADDR_WIDTH'(32'(address_to_write) % DEPTH);
    assign rd_idx = ADDR_WIDTH'(32'(address_to_read) % DEPTH);

    assign wr_accept = wr_cs & wr_en & ~full_reg;
    assign rd_req    = rd_cs & rd_en;
    assign rd_count  = rd_req & (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        if (wr_accept && !rd_count)
            count_next = count_reg + CW'(1);
        else if (rd_count && !wr_accept)
            count_next = count_reg - CW'(1);
    end

    // Whole-array clear on reset rules out a block-RAM mapping; storage is flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (wr_accept) begin
            mem_reg[wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg <= '0;
            count_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
        end else begin
            if (rd_req)
                data_out_reg <= mem_reg[rd_idx];
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == DEPTH_CNT);
        end
    end

    assign data_out = data_out_reg;
    assign empty    = empty_reg;
    assign full     = full_reg;

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Randomized scoreboard bench for sync_fifo_mem: a queue/array reference model predicts
// data_out/empty/full per cycle; a monitor pops and compares after each clock edge.
`timescale 1ns/1ps
module tb_sync_fifo_mem;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_cs = 0, wr_en = 0, rd_cs = 0, rd_en = 0;
    logic [5:0]  address_to_write = '0, address_to_read = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        empty, full;

    logic        rst_b = 1'b1;
    logic        wr_cs_b = 0, wr_en_b = 0, rd_cs_b = 0, rd_en_b = 0;
    logic [5:0]  address_to_write_b = '0, address_to_read_b = '0;
    logic [15:0] data_in_b = '0;
    logic [15:0] data_out_b;
    logic        empty_b, full_b;

    always #5 clk = ~clk;

    sync_fifo_mem dut (
        .clk(clk), .rst(rst),
        .wr_cs(wr_cs), .wr_en(wr_en), .address_to_write(address_to_write), .data_in(data_in),
        .rd_cs(rd_cs), .rd_en(rd_en), .address_to_read(address_to_read),
        .data_out(data_out), .empty(empty), .full(full)
    );

    sync_fifo_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(64)) dut_b (
        .clk(clk), .rst(rst_b),
        .wr_cs(wr_cs_b), .wr_en(wr_en_b), .address_to_write(address_to_write_b), .data_in(data_in_b),
        .rd_cs(rd_cs_b), .rd_en(rd_en_b), .address_to_read(address_to_read_b),
        .data_out(data_out_b), .empty(empty_b), .full(full_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        empty;
        logic        full;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_data;
    int          m_count;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          txn      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_data  = '0;
        m_count = 0;
    endtask

    // Drives one transaction at a negedge, predicts its outcome, then idles at the next negedge.
    task automatic cycle(input bit wcs, input bit wen, input int waddr, input logic [31:0] wdata,
                         input bit rcs, input bit ren, input int raddr);
        bit rd, wacc, rd_counted;
        wr_cs = wcs; wr_en = wen; address_to_write = 6'(waddr); data_in = wdata;
        rd_cs = rcs; rd_en = ren; address_to_read = 6'(raddr);
        rd         = rcs && ren;
        wacc       = wcs && wen && (m_count < DEPTH);
        rd_counted = rd && (m_count > 0);
        if (rd)   m_data = m_mem[raddr % DEPTH];
        if (wacc) m_mem[waddr % DEPTH] = wdata;
        if (wacc && !rd_counted)      m_count++;
        else if (rd_counted && !wacc) m_count--;
        txn++;
        $display("txn %0d: wr(cs=%0b en=%0b a=%0d d=%h) rd(cs=%0b en=%0b a=%0d) -> exp data=%h count=%0d",
                 txn, wcs, wen, waddr, wdata, rcs, ren, raddr, m_data, m_count);
        sb.push_back('{m_data, (m_count == 0), (m_count == DEPTH), txn});
        @(negedge clk);
        wr_cs = 0; wr_en = 0; rd_cs = 0; rd_en = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("data_out txn%0d", e.tag), data_out, e.data);
                chk($sformatf("empty txn%0d", e.tag), {31'b0, empty}, {31'b0, e.empty});
                chk($sformatf("full txn%0d", e.tag), {31'b0, full}, {31'b0, e.full});
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int wp;
        model_reset();
        #2;
        rst = 1'b0; rst_b = 1'b0;
        #1;
        chk("reset empty", {31'b0, empty}, 32'd1);
        chk("reset full", {31'b0, full}, 32'd0);
        chk("reset data_out", data_out, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1; rst_b = 1'b1;

        // Read after reset, then write/read of one word
        cycle(0, 0, 0, 0, 1, 1, 5);
        cycle(1, 1, 3, 32'hA5A5_0001, 0, 0, 0);
        chk("empty after write", {31'b0, empty}, 32'd0);
        cycle(0, 0, 0, 0, 1, 1, 3);
        chk("read back A5A5_0001", data_out, 32'hA5A5_0001);

        // Fill all 64 words, then one dropped write
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, i, 32'h100 + i, 0, 0, 0);
        chk("full after 64 writes", {31'b0, full}, 32'd1);
        cycle(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
        // Read+write while full: write dropped, count falls to 63, old word returned
        cycle(1, 1, 0, 32'hCAFE_0000, 1, 1, 0);
        chk("mem[0] kept after dropped writes", data_out, 32'h100);
        chk("full cleared at 63", {31'b0, full}, 32'd0);
        for (int i = 0; i < 53; i++) cycle(0, 0, 0, 0, 1, 1, i);
        // count 10: simultaneous write and read leaves it at 10; read-before-write on same address
        cycle(1, 1, 20, 32'h1234_5678, 1, 1, 20);
        chk("read-before-write", data_out, 32'h100 + 20);
        // Gated requests: no change
        cycle(0, 0, 0, 0, 1, 0, 20);
        cycle(0, 1, 21, 32'hFFFF_FFFF, 0, 0, 0);
        cycle(1, 0, 22, 32'hEEEE_EEEE, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1, 20 + i);
        cycle(0, 0, 0, 0, 1, 1, 21);

        // Randomized traffic: write-heavy then read-heavy so both bounds get exercised
        for (int i = 0; i < 600; i++) begin
            wp = (i % 200 < 100) ? 75 : 25;
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 9) != 0, $urandom_range(0, 63), $urandom,
                  $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 9) != 0, $urandom_range(0, 63));
        end

        // Asynchronous reset between edges, then normal operation resumes
        #2;
        rst = 1'b0;
        #1;
        chk("async rst empty", {31'b0, empty}, 32'd1);
        chk("async rst full", {31'b0, full}, 32'd0);
        chk("async rst data_out", data_out, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 0, 0, 1, 1, 3);
        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 1), 1, $urandom_range(0, 63), $urandom,
                  $urandom_range(0, 1), 1, $urandom_range(0, 63));

        // 16-bit instance
        wr_cs_b = 1; wr_en_b = 1; address_to_write_b = 6'd7; data_in_b = 16'hBEEF;
        @(negedge clk);
        wr_cs_b = 0; wr_en_b = 0;
        chk("b empty after write", {31'b0, empty_b}, 32'd0);
        rd_cs_b = 1; rd_en_b = 1; address_to_read_b = 6'd7;
        @(negedge clk);
        rd_cs_b = 0; rd_en_b = 0;
        chk("b read BEEF", {16'b0, data_out_b}, 32'h0000_BEEF);
        wr_cs_b = 1; wr_en_b = 1; address_to_write_b = 6'd8; data_in_b = 16'h1111;
        #2;
        rst_b = 1'b0;
        #1;
        chk("b async rst empty", {31'b0, empty_b}, 32'd1);
        chk("b async rst data_out", {16'b0, data_out_b}, 32'd0);
        chk("b async rst full", {31'b0, full_b}, 32'd0);
        @(negedge clk);
        wr_cs_b = 0; wr_en_b = 0;
        rst_b = 1'b1;
        rd_cs_b = 1; rd_en_b = 1; address_to_read_b = 6'd7;
        @(negedge clk);
        rd_cs_b = 0; rd_en_b = 0;
        chk("b mem cleared by rst", {16'b0, data_out_b}, 32'd0);

        @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
